// File: rtl/svc_rv_store_buf_pkg.sv
// Shared types for the committed-store buffer: the entry layout
// and the byte-strobe width.
package svc_rv_store_buf_pkg;

  localparam int SB_STRB_W = 4;
  localparam int SB_AW     = 32;
  localparam int SB_DW     = 32;

  typedef struct packed {
    logic [SB_AW-1:0]     addr;
    logic [SB_DW-1:0]     data;
    logic [SB_STRB_W-1:0] strb;
  } store_entry_t;

endpackage

// File: rtl/svc_rv_store_buf_match.sv
// Load-vs-pending-store comparator: per-entry word/byte overlap test and,
// when SVC_RV_STORE_BUF_FWD_EN is defined, youngest-first select.
// Ports: i_tag/i_strb/i_vld entry view, i_ld_tag/i_ld_strb lookup,
//        i_wr_ptr (fwd only), o_any_match, o_multi_match/o_sel_idx (fwd only).
module svc_rv_store_buf_match
  import svc_rv_store_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TW    = 30,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [TW-1:0]        i_tag    [DEPTH],
  input  logic [SB_STRB_W-1:0] i_strb   [DEPTH],
  input  logic [DEPTH-1:0]     i_vld,
  input  logic [TW-1:0]        i_ld_tag,
  input  logic [SB_STRB_W-1:0] i_ld_strb,
`ifdef SVC_RV_STORE_BUF_FWD_EN
  input  logic [PW-1:0]        i_wr_ptr,
  output logic                 o_multi_match,
  output logic [PW-1:0]        o_sel_idx,
`endif
  output logic                 o_any_match
);

  logic [DEPTH-1:0] w_match;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = i_vld[i]
                && (i_tag[i] == i_ld_tag)
                && (|(i_strb[i] & i_ld_strb));
    end
  end

  assign o_any_match = |w_match;

`ifdef SVC_RV_STORE_BUF_FWD_EN
  logic [CW-1:0] w_cnt;
  logic [PW-1:0] w_idx;
  logic          w_found;

  // Walk from the newest slot (wr_ptr-1) back to the oldest.
  always_comb begin
    w_cnt     = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    o_sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + {{PW{1'b0}}, w_match[i]};
    end
    for (int k = 1; k <= DEPTH; k++) begin
      w_idx = i_wr_ptr - PW'(k);
      if (!w_found && w_match[w_idx]) begin
        w_found   = 1'b1;
        o_sel_idx = w_idx;
      end
    end
  end

  assign o_multi_match = w_cnt > CW'(1);
`endif

endmodule

// File: rtl/svc_rv_store_buf.sv
// Committed-store FIFO between MEM and a multi-cycle data memory, with
// load overlap check. Macro SVC_RV_STORE_BUF_FWD_EN enables forwarding.
// Ports: i_clk/i_rst, i_st_* enqueue, i_ld_*/o_ld_* lookup,
//        o_mem_wr_*/i_mem_wr_ready drain, o_empty, o_count.
module svc_rv_store_buf
  import svc_rv_store_buf_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_st_valid,
  output logic                 o_st_ready,
  input  logic [AW-1:0]        i_st_addr,
  input  logic [DW-1:0]        i_st_data,
  input  logic [SB_STRB_W-1:0] i_st_strb,
  input  logic                 i_ld_valid,
  input  logic [AW-1:0]        i_ld_addr,
  input  logic [SB_STRB_W-1:0] i_ld_strb,
  output logic                 o_ld_hit,
  output logic [DW-1:0]        o_ld_data,
  output logic                 o_ld_conflict,
  output logic                 o_mem_wr_valid,
  input  logic                 i_mem_wr_ready,
  output logic [AW-1:0]        o_mem_wr_addr,
  output logic [DW-1:0]        o_mem_wr_data,
  output logic [SB_STRB_W-1:0] o_mem_wr_strb,
  output logic                 o_empty,
  output logic [CW-1:0]        o_count
);

  store_entry_t r_ent [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = r_count == CW'(DEPTH);
  assign w_empty = r_count == '0;
  // Full blocks the store even if a drain frees a slot this cycle.
  assign w_enq   = i_st_valid && !w_full;
  assign w_deq   = !w_empty && i_mem_wr_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_ent[r_wr_ptr] <= '{addr: SB_AW'(i_st_addr),
                           data: SB_DW'(i_st_data),
                           strb: i_st_strb};
    end
  end

  assign o_st_ready     = !w_full;
  assign o_empty        = w_empty;
  assign o_count        = r_count;
  assign o_mem_wr_valid = !w_empty;
  assign o_mem_wr_addr  = AW'(r_ent[r_rd_ptr].addr);
  assign o_mem_wr_data  = DW'(r_ent[r_rd_ptr].data);
  assign o_mem_wr_strb  = r_ent[r_rd_ptr].strb;

  logic [DEPTH-1:0]     w_vld;
  logic [PW-1:0]        w_off;
  logic [AW-3:0]        w_tag  [DEPTH];
  logic [SB_STRB_W-1:0] w_strb [DEPTH];

  // Slot i is live when its distance from rd_ptr is below count.
  always_comb begin
    w_vld = '0;
    w_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off     = PW'(i) - r_rd_ptr;
      w_vld[i]  = {1'b0, w_off} < r_count;
      w_tag[i]  = r_ent[i].addr[AW-1:2];
      w_strb[i] = r_ent[i].strb;
    end
  end

  logic w_any;

`ifdef SVC_RV_STORE_BUF_FWD_EN
  logic          w_multi;
  logic [PW-1:0] w_sel;
  logic          w_hit;

  svc_rv_store_buf_match #(
    .DEPTH (DEPTH),
    .TW    (AW-2)
  ) u_match (
    .i_tag         (w_tag),
    .i_strb        (w_strb),
    .i_vld         (w_vld),
    .i_ld_tag      (i_ld_addr[AW-1:2]),
    .i_ld_strb     (i_ld_strb),
    .i_wr_ptr      (r_wr_ptr),
    .o_multi_match (w_multi),
    .o_sel_idx     (w_sel),
    .o_any_match   (w_any)
  );

  // Forward only when a single store fully covers the load bytes.
  assign w_hit = i_ld_valid && w_any && !w_multi
              && ((r_ent[w_sel].strb & i_ld_strb) == i_ld_strb);

  assign o_ld_hit      = w_hit;
  assign o_ld_data     = w_hit ? DW'(r_ent[w_sel].data) : '0;
  assign o_ld_conflict = i_ld_valid && w_any && !w_hit;
`else
  svc_rv_store_buf_match #(
    .DEPTH (DEPTH),
    .TW    (AW-2)
  ) u_match (
    .i_tag       (w_tag),
    .i_strb      (w_strb),
    .i_vld       (w_vld),
    .i_ld_tag    (i_ld_addr[AW-1:2]),
    .i_ld_strb   (i_ld_strb),
    .o_any_match (w_any)
  );

  assign o_ld_hit      = 1'b0;
  assign o_ld_data     = '0;
  assign o_ld_conflict = i_ld_valid && w_any;
`endif

endmodule

// File: tb/tb_svc_rv_store_buf.sv
// Scoreboard bench for svc_rv_store_buf: expected memory writes and
// load lookups are queued by stimulus and checked by a monitor.
module tb_svc_rv_store_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_strb;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_conflict;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  svc_rv_store_buf dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_st_valid     (st_valid),
    .o_st_ready     (st_ready),
    .i_st_addr      (st_addr),
    .i_st_data      (st_data),
    .i_st_strb      (st_strb),
    .i_ld_valid     (ld_valid),
    .i_ld_addr      (ld_addr),
    .i_ld_strb      (ld_strb),
    .o_ld_hit       (ld_hit),
    .o_ld_data      (ld_data),
    .o_ld_conflict  (ld_conflict),
    .o_mem_wr_valid (mem_wr_valid),
    .i_mem_wr_ready (mem_wr_ready),
    .o_mem_wr_addr  (mem_wr_addr),
    .o_mem_wr_data  (mem_wr_data),
    .o_mem_wr_strb  (mem_wr_strb),
    .o_empty        (empty),
    .o_count        (count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  typedef struct {
    logic        h;
    logic        c;
    logic [31:0] d;
  } ld_t;

  wr_t wq[$];
  ld_t lq[$];
  int n_chk  = 0;
  int n_fail = 0;

  always @(negedge clk) begin : monitor
    wr_t we;
    ld_t le;
    if (mem_wr_valid && mem_wr_ready) begin
      n_chk++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr %h, expected none",
                 mem_wr_addr);
      end else begin
        we = wq.pop_front();
        if (mem_wr_addr !== we.a || mem_wr_data !== we.d
            || mem_wr_strb !== we.s) begin
          n_fail++;
          $display("FAIL wr_order: got %h/%h/%h, expected %h/%h/%h",
                   mem_wr_addr, mem_wr_data, mem_wr_strb,
                   we.a, we.d, we.s);
        end
      end
    end
    if (ld_valid) begin
      n_chk++;
      if (lq.size() == 0) begin
        n_fail++;
        $display("FAIL ld_unexpected: addr %h, expected none", ld_addr);
      end else begin
        le = lq.pop_front();
        if (ld_hit !== le.h || ld_conflict !== le.c
            || ld_data !== le.d) begin
          n_fail++;
          $display("FAIL ld %h/%b: got hit=%b conf=%b data=%h, expected hit=%b conf=%b data=%h",
                   ld_addr, ld_strb, ld_hit, ld_conflict, ld_data,
                   le.h, le.c, le.d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq1(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit push);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_strb  = s;
    if (push) wq.push_back('{a: a, d: d, s: s});
    step();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] s,
                      input logic h, input logic c,
                      input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_strb  = s;
    lq.push_back('{h: h, c: c, d: d});
    @(negedge clk);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic drain_all();
    int t;
    t = 0;
    mem_wr_ready = 1'b1;
    while (!empty && t < 40) begin
      step();
      t++;
    end
    mem_wr_ready = 1'b0;
    chk("drain_done", {31'd0, empty}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    st_valid     = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    st_strb      = '0;
    ld_valid     = 1'b0;
    ld_addr      = '0;
    ld_strb      = '0;
    mem_wr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_wr_valid", {31'd0, mem_wr_valid}, 32'd0);
    chk("rst_ld_hit", {31'd0, ld_hit}, 32'd0);
    chk("rst_ld_conf", {31'd0, ld_conflict}, 32'd0);
    step();

    for (int i = 0; i < 4; i++) begin
      enq1(32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1);
    end
    st_valid = 1'b1;
    st_addr  = 32'h500;
    st_data  = 32'h5555_5555;
    st_strb  = 4'hF;
    @(negedge clk);
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    chk("full_count", {29'd0, count}, 32'd4);
    step();
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_no_enq", {29'd0, count}, 32'd4);
    chk("full_head", mem_wr_addr, 32'h100);
    step();
    mem_wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_count", {29'd0, count}, 32'(4 - k));
      step();
    end
    @(negedge clk);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_wr_valid", {31'd0, mem_wr_valid}, 32'd0);
    step();
    mem_wr_ready = 1'b0;

    enq1(32'h200, 32'hDEAD_BEEF, 4'hF, 1'b1);
`ifdef SVC_RV_STORE_BUF_FWD_EN
    load(32'h202, 4'b1100, 1'b1, 1'b0, 32'hDEAD_BEEF);
    load(32'h200, 4'b0001, 1'b1, 1'b0, 32'hDEAD_BEEF);
`else
    load(32'h202, 4'b1100, 1'b0, 1'b1, 32'h0);
    load(32'h200, 4'b0001, 1'b0, 1'b1, 32'h0);
`endif
    load(32'h204, 4'hF, 1'b0, 1'b0, 32'h0);
    enq1(32'h300, 32'h0000_0011, 4'b0001, 1'b1);
    load(32'h300, 4'hF, 1'b0, 1'b1, 32'h0);
    enq1(32'h300, 32'h0000_2200, 4'hF, 1'b1);
    load(32'h300, 4'b0001, 1'b0, 1'b1, 32'h0);
`ifdef SVC_RV_STORE_BUF_FWD_EN
    load(32'h300, 4'b0010, 1'b1, 1'b0, 32'h0000_2200);
`else
    load(32'h300, 4'b0010, 1'b0, 1'b1, 32'h0);
`endif
    drain_all();

    for (int i = 0; i < 4; i++) begin
      enq1(32'h400 + 32'(4*i), 32'h4000 + 32'(i), 4'hF, 1'b1);
    end
    st_valid     = 1'b1;
    st_addr      = 32'h480;
    st_data      = 32'h4444;
    st_strb      = 4'h3;
    mem_wr_ready = 1'b1;
    @(negedge clk);
    chk("conc_st_ready", {31'd0, st_ready}, 32'd0);
    step();
    mem_wr_ready = 1'b0;
    @(negedge clk);
    chk("conc_count3", {29'd0, count}, 32'd3);
    chk("conc_ready1", {31'd0, st_ready}, 32'd1);
    wq.push_back('{a: 32'h480, d: 32'h4444, s: 4'h3});
    step();
    st_valid = 1'b0;
    @(negedge clk);
    chk("conc_count4", {29'd0, count}, 32'd4);
    step();
    drain_all();

    for (int i = 0; i < 10; i++) begin
      enq1(32'h700 + 32'(4*i), 32'h7000 + 32'(i), 4'(i), 1'b1);
      mem_wr_ready = 1'b1;
      step();
      mem_wr_ready = 1'b0;
    end
    @(negedge clk);
    chk("alt_count", {29'd0, count}, 32'd0);
    step();

    mem_wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      st_valid = 1'b1;
      st_addr  = 32'h600 + 32'(4*i);
      st_data  = 32'h6000 + 32'(i);
      st_strb  = 4'hF;
      wq.push_back('{a: st_addr, d: st_data, s: 4'hF});
      step();
      @(negedge clk);
      chk("stream_count", {29'd0, count}, 32'd1);
    end
    st_valid = 1'b0;
    step();
    mem_wr_ready = 1'b0;
    @(negedge clk);
    chk("stream_empty", {31'd0, empty}, 32'd1);
    step();

    enq1(32'h800, 32'h8, 4'hF, 1'b0);
    enq1(32'h804, 32'h9, 4'hF, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr_valid", {31'd0, mem_wr_valid}, 32'd0);
    chk("mrst_count", {29'd0, count}, 32'd0);
    chk("mrst_empty", {31'd0, empty}, 32'd1);
    chk("mrst_st_ready", {31'd0, st_ready}, 32'd1);
    step();

    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("lq_left", 32'(lq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
